// File: rtl/mstage_lsu_pkg.sv
// mstage_lsu shared types: size codes, FSM states, AXI resp codes.
// Optional misalign trap: CONFIG_LSU_ALIGN_CHECK_EN.
package mstage_lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_DONE
  } state_e;

  typedef struct packed {
    logic            ld;
    logic [1:0]      size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    unique case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mstage_lsu_if.sv
// mstage_lsu bus bundle: E/W-stage handshakes plus AXI4-Lite master.
// master = LSU side, slave = pipeline/memory side.
interface mstage_lsu_if;
  import mstage_lsu_pkg::*;

  logic            s_valid;
  logic            s_ready;
  logic            ren;
  logic            wen;
  logic [1:0]      size;
  logic            uns;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;

  logic            m_valid;
  logic            m_ready;
  logic [XLEN-1:0] mdata;
  logic            fault;

  logic [XLEN-1:0] araddr;
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  logic [XLEN-1:0] awaddr;
  logic            awvalid;
  logic            awready;
  logic [XLEN-1:0] wdata_o;
  logic [3:0]      wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    input  s_valid, ren, wen, size,
    input  uns, addr, wdata, m_ready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid,
    output s_ready, m_valid, mdata, fault,
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata_o,
    output wstrb, wvalid, bready
  );

  modport slave (
    output s_valid, ren, wen, size,
    output uns, addr, wdata, m_ready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid,
    input  s_ready, m_valid, mdata, fault,
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata_o,
    input  wstrb, wvalid, bready
  );

endinterface

// File: rtl/mstage_lsu_lane_align.sv
// lsu_lane_align: store lane replication/strobes and load
// shift/extend; lanes pushed past byte 3 are dropped.
module lsu_lane_align
  import mstage_lsu_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] ldata
);

  logic [3:0]      mask;
  logic [XLEN-1:0] sh;
  logic            sgn;

  always_comb begin
    mask    = 4'hf;
    wdata_o = wdata;
    unique case (size)
      SZ_B: begin
        mask    = 4'h1;
        wdata_o = {4{wdata[7:0]}};
      end
      SZ_H: begin
        mask    = 4'h3;
        wdata_o = {2{wdata[15:0]}};
      end
      default: begin
        mask    = 4'hf;
        wdata_o = wdata;
      end
    endcase
  end

  assign wstrb = mask << off;
  assign sh    = rdata >> {off, 3'b000};

  always_comb begin
    sgn   = 1'b0;
    ldata = sh;
    unique case (size)
      SZ_B: begin
        sgn   = ~uns & sh[7];
        ldata = {{24{sgn}}, sh[7:0]};
      end
      SZ_H: begin
        sgn   = ~uns & sh[15];
        ldata = {{16{sgn}}, sh[15:0]};
      end
      default: begin
        sgn   = 1'b0;
        ldata = sh;
      end
    endcase
  end

endmodule

// File: rtl/mstage_lsu.sv
// mstage_lsu: M-stage load/store unit, one AXI4-Lite access in flight.
// Define CONFIG_LSU_ALIGN_CHECK_EN to trap misaligned accesses.
module mstage_lsu
  import mstage_lsu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mstage_lsu_if.master bus
);

  state_e          state_q;
  state_e          state_d;
  req_t            req_q;
  logic [1:0]      resp_q;
  logic [XLEN-1:0] rdata_q;
  logic            mis_q;
  logic            aw_done_q;
  logic            w_done_q;

  logic            accept;
  logic            mis_in;
  logic            mem_op;
  logic            aw_hs;
  logic            w_hs;
  logic            aw_ok;
  logic            w_ok;
  logic [XLEN-1:0] rep_data;
  logic [3:0]      rep_strb;
  logic [XLEN-1:0] ldata;

  lsu_lane_align u_align (
    .size    (req_q.size),
    .uns     (req_q.uns),
    .off     (req_q.addr[1:0]),
    .wdata   (req_q.wdata),
    .rdata   (rdata_q),
    .wdata_o (rep_data),
    .wstrb   (rep_strb),
    .ldata   (ldata)
  );

  assign accept = bus.s_valid & (state_q == S_IDLE);
  assign mem_op = bus.ren | bus.wen;

`ifdef CONFIG_LSU_ALIGN_CHECK_EN
  assign mis_in = misaligned(bus.size, bus.addr[1:0]);
`else
  assign mis_in = 1'b0;
`endif

  // AW and W complete independently; B waits on both.
  assign aw_hs = (state_q == S_WR) & ~aw_done_q & bus.awready;
  assign w_hs  = (state_q == S_WR) & ~w_done_q & bus.wready;
  assign aw_ok = aw_done_q | aw_hs;
  assign w_ok  = w_done_q | w_hs;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.s_valid) begin
          if (mis_in & mem_op) state_d = S_DONE;
          else if (bus.ren)    state_d = S_AR;
          else if (bus.wen)    state_d = S_WR;
          else                 state_d = S_DONE;
        end
      end
      S_AR:   if (bus.arready) state_d = S_R;
      S_R:    if (bus.rvalid)  state_d = S_DONE;
      S_WR:   if (aw_ok & w_ok) state_d = S_B;
      S_B:    if (bus.bvalid)  state_d = S_DONE;
      S_DONE: if (bus.m_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready = 1'b0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.m_valid = 1'b0;
    bus.wdata_o = '0;
    bus.wstrb   = '0;
    bus.mdata   = '0;
    bus.fault   = 1'b0;
    unique case (state_q)
      S_IDLE: bus.s_ready = 1'b1;
      S_AR:   bus.arvalid = 1'b1;
      S_R:    bus.rready  = 1'b1;
      S_WR: begin
        bus.awvalid = ~aw_done_q;
        bus.wvalid  = ~w_done_q;
        bus.wdata_o = rep_data;
        bus.wstrb   = rep_strb;
      end
      S_B:    bus.bready  = 1'b1;
      S_DONE: begin
        bus.m_valid = 1'b1;
        bus.fault   = (resp_q != RESP_OKAY) | mis_q;
        if (req_q.ld & ~mis_q) bus.mdata = ldata;
      end
      default: bus.s_ready = 1'b0;
    endcase
  end

  assign bus.araddr = {req_q.addr[XLEN-1:2], 2'b00};
  assign bus.awaddr = {req_q.addr[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      mis_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.ld    <= bus.ren;
        req_q.size  <= bus.size;
        req_q.uns   <= bus.uns;
        req_q.addr  <= bus.addr;
        req_q.wdata <= bus.wdata;
        resp_q      <= RESP_OKAY;
        rdata_q     <= '0;
        mis_q       <= mis_in & mem_op;
      end
      if ((state_q == S_R) & bus.rvalid) begin
        rdata_q <= bus.rdata;
        resp_q  <= bus.rresp;
      end
      if ((state_q == S_B) & bus.bvalid) begin
        resp_q <= bus.bresp;
      end
      if (state_q == S_WR) begin
        if (aw_ok & w_ok) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          aw_done_q <= aw_ok;
          w_done_q  <= w_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_mstage_lsu.sv
// tb_mstage_lsu: directed loads/stores against a small AXI4-Lite
// slave model; expected values are hand-computed constants.
module tb_mstage_lsu;
  import mstage_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mstage_lsu_if bus();

  mstage_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  int          ar_wait_cfg = 0;
  logic        r_hold      = 1'b0;
  logic [31:0] rdata_cfg   = '0;
  logic [1:0]  rresp_cfg   = RESP_OKAY;
  logic [1:0]  bresp_cfg   = RESP_OKAY;

  logic hs_ar, hs_r, hs_aw, hs_w, hs_b;
  int          cyc = 0;
  int          aw_cyc, w_cyc, acc_cyc;
  logic [31:0] aw_addr_seen, w_data_seen;
  logic [3:0]  w_strb_seen;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    hs_ar <= bus.arvalid & bus.arready & ~rst;
    hs_r  <= bus.rvalid & bus.rready & ~rst;
    hs_aw <= bus.awvalid & bus.awready & ~rst;
    hs_w  <= bus.wvalid & bus.wready & ~rst;
    hs_b  <= bus.bvalid & bus.bready & ~rst;
    if (bus.awvalid & bus.awready) begin
      aw_cyc       <= cyc;
      aw_addr_seen <= bus.awaddr;
    end
    if (bus.wvalid & bus.wready) begin
      w_cyc       <= cyc;
      w_data_seen <= bus.wdata_o;
      w_strb_seen <= bus.wstrb;
    end
  end

  int   ar_cnt;
  logic aw_got, w_got;

  always @(negedge clk) begin
    if (rst) begin
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = '0;
      bus.rresp   = '0;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = '0;
      ar_cnt      = 0;
      aw_got      = 1'b0;
      w_got       = 1'b0;
    end else begin
      if (hs_r) bus.rvalid = 1'b0;
      if (hs_ar) begin
        bus.arready = 1'b0;
        ar_cnt      = 0;
        if (!r_hold) begin
          bus.rvalid = 1'b1;
          bus.rdata  = rdata_cfg;
          bus.rresp  = rresp_cfg;
        end
      end else if (bus.arvalid && !bus.arready) begin
        if (ar_cnt >= ar_wait_cfg) bus.arready = 1'b1;
        else ar_cnt++;
      end
      if (hs_aw) begin
        bus.awready = 1'b0;
        aw_got      = 1'b1;
      end else if (bus.awvalid) bus.awready = 1'b1;
      if (hs_w) begin
        bus.wready = 1'b0;
        w_got      = 1'b1;
      end else if (bus.wvalid) bus.wready = 1'b1;
      if (hs_b) bus.bvalid = 1'b0;
      else if (aw_got && w_got) begin
        bus.bvalid = 1'b1;
        bus.bresp  = bresp_cfg;
        aw_got     = 1'b0;
        w_got      = 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic r, input logic w,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.ren     = r;
    bus.wen     = w;
    bus.size    = sz;
    bus.uns     = u;
    bus.addr    = a;
    bus.wdata   = wd;
    @(posedge clk);
    #1;
    acc_cyc     = cyc - 1;
    bus.s_valid = 1'b0;
    bus.ren     = 1'b0;
    bus.wen     = 1'b0;
    bus.size    = 2'b11;
    bus.uns     = 1'b1;
    bus.addr    = 32'hffff_ffff;
    bus.wdata   = 32'h5555_aaaa;
  endtask

  task automatic run(input logic r, input logic w,
                     input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output int arv);
    lat = 0;
    arv = 0;
    accept(r, w, sz, u, a, wd);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      chk("busy_s_ready", bus.s_ready, 0);
      if (bus.arvalid) begin
        arv++;
        chk("araddr", bus.araddr, {a[31:2], 2'b00});
      end
      if (bus.m_valid) break;
    end
    chk("m_valid_timeout", bus.m_valid, 1);
  endtask

  task automatic ack();
    @(negedge clk);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
  endtask

  int lat, arv;

  initial begin
    bus.s_valid = 1'b0;
    bus.ren     = 1'b0;
    bus.wen     = 1'b0;
    bus.size    = '0;
    bus.uns     = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_valids", {bus.arvalid, bus.rready, bus.awvalid,
                       bus.wvalid, bus.bready, bus.m_valid}, 0);
    chk("rst_mdata", bus.mdata, 0);
    chk("rst_fault", bus.fault, 0);

    rdata_cfg = 32'h80ff_ffff;
    run(1, 0, SZ_B, 0, 32'h8000_0003, 0, lat, arv);
    chk("lb_lat", lat, 3);
    chk("lb_mdata", bus.mdata, 32'hffff_ff80);
    chk("lb_fault", bus.fault, 0);
    ack();

    run(0, 1, SZ_H, 0, 32'h8000_0002, 32'h0000_1234, lat, arv);
    chk("sh_wdata", w_data_seen, 32'h1234_1234);
    chk("sh_wstrb", w_strb_seen, 4'b1100);
    chk("sh_aw_cyc", aw_cyc, 32'(acc_cyc + 1));
    chk("sh_w_cyc", w_cyc, 32'(acc_cyc + 1));
    chk("sh_awaddr", aw_addr_seen, 32'h8000_0000);
    chk("sh_mdata", bus.mdata, 0);
    chk("sh_fault", bus.fault, 0);
    chk("sh_arv", arv, 0);
    ack();

    run(0, 0, SZ_W, 0, 32'h1234_5678, 0, lat, arv);
    chk("nop_lat", lat, 1);
    chk("nop_mdata", bus.mdata, 0);
    chk("nop_fault", bus.fault, 0);
    chk("nop_arv", arv, 0);
    ack();

    ar_wait_cfg = 5;
    rdata_cfg   = 32'h1234_5678;
    run(1, 0, SZ_W, 0, 32'h8000_0040, 0, lat, arv);
    chk("lw_arv", arv, 6);
    chk("lw_lat", lat, 8);
    chk("lw_mdata", bus.mdata, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_m_valid", bus.m_valid, 1);
      chk("hold_mdata", bus.mdata, 32'h1234_5678);
      chk("hold_s_ready", bus.s_ready, 0);
    end
    ack();
    @(negedge clk);
    chk("lw_s_ready_after", bus.s_ready, 1);
    ar_wait_cfg = 0;

    bresp_cfg = RESP_SLVERR;
    run(0, 1, SZ_W, 0, 32'h8000_0010, 32'hcafe_f00d, lat, arv);
    chk("sw_wstrb", w_strb_seen, 4'hf);
    chk("sw_wdata", w_data_seen, 32'hcafe_f00d);
    chk("sw_fault", bus.fault, 1);
    chk("sw_mdata", bus.mdata, 0);
    ack();
    bresp_cfg = RESP_OKAY;

    rresp_cfg = RESP_SLVERR;
    rdata_cfg = 32'h0000_0000;
    run(1, 0, SZ_W, 0, 32'h8000_0020, 0, lat, arv);
    chk("lw_err_fault", bus.fault, 1);
    ack();
    rresp_cfg = RESP_OKAY;

    rdata_cfg = 32'hbeef_0000;
    run(1, 0, SZ_H, 1, 32'h8000_0002, 0, lat, arv);
    chk("lhu_mdata", bus.mdata, 32'h0000_beef);
    chk("lhu_fault", bus.fault, 0);
    ack();

    rdata_cfg = 32'h0000_8001;
    run(1, 0, SZ_H, 0, 32'h8000_0000, 0, lat, arv);
    chk("lh_mdata", bus.mdata, 32'hffff_8001);
    ack();

    rdata_cfg = 32'h0000_f000;
    run(1, 0, SZ_B, 1, 32'h8000_0001, 0, lat, arv);
    chk("lbu_mdata", bus.mdata, 32'h0000_00f0);
    ack();

    run(0, 1, SZ_B, 0, 32'h8000_0001, 32'h0000_00a5, lat, arv);
    chk("sb_wdata", w_data_seen, 32'ha5a5_a5a5);
    chk("sb_wstrb", w_strb_seen, 4'b0010);
    ack();

    rdata_cfg = 32'h0bad_cafe;
    run(1, 1, SZ_W, 0, 32'h8000_0008, 32'h1111_1111, lat, arv);
    chk("rw_lat", lat, 3);
    chk("rw_arv", arv, 1);
    chk("rw_mdata", bus.mdata, 32'h0bad_cafe);
    ack();

`ifdef CONFIG_LSU_ALIGN_CHECK_EN
    run(1, 0, SZ_W, 0, 32'h8000_0001, 0, lat, arv);
    chk("mis_arv", arv, 0);
    chk("mis_lat", lat, 1);
    chk("mis_fault", bus.fault, 1);
    chk("mis_mdata", bus.mdata, 0);
    ack();
`else
    rdata_cfg = 32'haabb_ccdd;
    run(1, 0, SZ_W, 0, 32'h8000_0001, 0, lat, arv);
    chk("mis_arv", arv, 1);
    chk("mis_mdata", bus.mdata, 32'h00aa_bbcc);
    chk("mis_fault", bus.fault, 0);
    ack();
    run(0, 1, SZ_W, 0, 32'h8000_0003, 32'h1122_3344, lat, arv);
    chk("mis_sw_wstrb", w_strb_seen, 4'b1000);
    chk("mis_sw_wdata", w_data_seen, 32'h1122_3344);
    ack();
`endif

    r_hold = 1'b1;
    accept(1, 0, SZ_W, 0, 32'h8000_0004, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rready) break;
    end
    chk("rr_seen", bus.rready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rr_s_ready", bus.s_ready, 1);
    chk("rr_valids", {bus.arvalid, bus.rready, bus.awvalid,
                      bus.wvalid, bus.bready, bus.m_valid}, 0);
    chk("rr_mdata", bus.mdata, 0);
    chk("rr_fault", bus.fault, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    r_hold = 1'b0;

    rdata_cfg = 32'h5a5a_5a5a;
    run(1, 0, SZ_W, 0, 32'h8000_0000, 0, lat, arv);
    chk("post_lat", lat, 3);
    chk("post_mdata", bus.mdata, 32'h5a5a_5a5a);
    ack();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
